ula_sequencial_bytes: RTL and testbench

- Multi-byte sequential ALU stage wrapped around the existing `ula_8_bits`.
- Latches wide operands, then feeds them to one internal `ula_8_bits` instance one byte per clock, LSB first.
- Chains the carry between bytes through a register and ANDs the per-byte `a_eq_b` flags.
- Presents registered wide results with a start/busy/done handshake. It sits directly upstream of `ula_8_bits`, driving all its inputs, and directly downstream of it, consuming all its outputs.

---
 rtl/ula_sequencial_bytes.sv | 186 ++++++++++++++++++
 tb/tb_ula_sequencial_bytes.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_sequencial_bytes.sv
// Multi-byte sequential ALU: streams latched wide operands through one 8-bit
// ALU slice, LSB first, chaining carry and equality between bytes.

module ula_8_bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [7:0] f,
  output logic       c_out,
  output logic       a_eq_b
);

  logic [7:0] p_s;
  logic [7:0] g_s;
  logic [8:0] sum_s;

  // 181-style slice with active-high carry; a_eq_b flags an all-ones result
  always_comb begin
    p_s   = a | (b & {8{s[0]}}) | (~b & {8{s[1]}});
    g_s   = (a & b & {8{s[3]}}) | (a & ~b & {8{s[2]}});
    sum_s = {1'b0, p_s} + {1'b0, g_s} + {8'd0, c_in};
    if (m) begin
      f = ~(p_s ^ g_s);
    end else begin
      f = sum_s[7:0];
    end
    c_out  = sum_s[8];
    a_eq_b = &f;
  end

endmodule

module ula_sequencial_bytes #(
  parameter int N_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [8*N_BYTES-1:0] a,
  input  logic [8*N_BYTES-1:0] b,
  input  logic [3:0]           s,
  input  logic                 m,
  input  logic                 c_in,
  output logic                 busy,
  output logic                 done,
  output logic [8*N_BYTES-1:0] f,
  output logic                 c_out,
  output logic                 a_eq_b
);

  localparam int W  = 8 * N_BYTES;
  localparam int IW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [W-1:0]    a_lat_r;
  logic [W-1:0]    b_lat_r;
  logic [3:0]      s_lat_r;
  logic            m_lat_r;
  logic            carry_r;
  logic            eq_acc_r;
  logic [W-1:0]    work_r;
  logic [IW-1:0]   idx_r;

  logic            accept_s;
  logic            last_s;
  logic [7:0]      a_byte_s;
  logic [7:0]      b_byte_s;
  logic [7:0]      f_byte_s;
  logic            c_byte_s;
  logic            eq_byte_s;
  logic [W-1:0]    work_next_s;

  // Byte select and working-word update for the current EXEC step
  always_comb begin
    accept_s    = start && ((state_r == IDLE) || (state_r == DONE));
    last_s      = (idx_r == LAST_IDX);
    a_byte_s    = a_lat_r[{idx_r, 3'b000} +: 8];
    b_byte_s    = b_lat_r[{idx_r, 3'b000} +: 8];
    work_next_s = work_r;
    work_next_s[{idx_r, 3'b000} +: 8] = f_byte_s;
  end

  ula_8_bits u_ula (
    .a      (a_byte_s),
    .b      (b_byte_s),
    .s      (s_lat_r),
    .m      (m_lat_r),
    .c_in   (carry_r),
    .f      (f_byte_s),
    .c_out  (c_byte_s),
    .a_eq_b (eq_byte_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; DONE always lasts one cycle
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = EXEC;
        end
      end
      DONE: begin
        if (accept_s) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register
  always_comb begin
    busy = (state_r == EXEC);
    done = (state_r == DONE);
  end

  // Operand latches, carry/equality chaining and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_lat_r  <= '0;
      b_lat_r  <= '0;
      s_lat_r  <= 4'd0;
      m_lat_r  <= 1'b0;
      carry_r  <= 1'b0;
      eq_acc_r <= 1'b0;
      work_r   <= '0;
      idx_r    <= '0;
      f        <= '0;
      c_out    <= 1'b0;
      a_eq_b   <= 1'b0;
    end else if (accept_s) begin
      a_lat_r  <= a;
      b_lat_r  <= b;
      s_lat_r  <= s;
      m_lat_r  <= m;
      carry_r  <= c_in;
      eq_acc_r <= 1'b1;
      idx_r    <= '0;
    end else if (state_r == EXEC) begin
      work_r   <= work_next_s;
      carry_r  <= c_byte_s;
      eq_acc_r <= eq_acc_r & eq_byte_s;
      if (last_s) begin
        f      <= work_next_s;
        c_out  <= c_byte_s;
        a_eq_b <= eq_acc_r & eq_byte_s;
      end else begin
        idx_r  <= idx_r + IW'(1);
      end
    end else begin
      idx_r <= idx_r;
    end
  end

endmodule

// File: tb/tb_ula_sequencial_bytes.sv
// Directed self-checking bench for ula_sequencial_bytes (4-byte and 1-byte builds).

module tb_ula_sequencial_bytes;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [3:0]  s = 4'd0;
  logic        m = 1'b0;
  logic        c_in = 1'b0;
  logic        busy, done, c_out, a_eq_b;
  logic [31:0] f;

  logic        start1 = 1'b0;
  logic [7:0]  a1 = 8'd0;
  logic [7:0]  b1 = 8'd0;
  logic        busy1, done1, c_out1, eq1;
  logic [7:0]  f1;

  int pass_cnt = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  ula_sequencial_bytes #(.N_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .s(s), .m(m),
    .c_in(c_in), .busy(busy), .done(done), .f(f), .c_out(c_out), .a_eq_b(a_eq_b)
  );

  ula_sequencial_bytes #(.N_BYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .s(s), .m(m),
    .c_in(c_in), .busy(busy1), .done(done1), .f(f1), .c_out(c_out1), .a_eq_b(eq1)
  );

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [3:0] ts, input logic tm, input logic tc,
                        output int lat, output int busy_cycles);
    @(negedge clk);
    a = ta; b = tb_v; s = ts; m = tm; c_in = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    busy_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_cnt++;
    if ({busy, done, c_out, a_eq_b} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {busy, done, c_out, a_eq_b});
    else pass_cnt++;
    check_cnt++;
    if (f !== 32'h0) $display("FAIL reset_f got %h want 00000000", f);
    else pass_cnt++;
    check_cnt++;
    if (f1 !== 8'h0) $display("FAIL reset_f1 got %h want 00", f1);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_logic_and();
    int lat, bc;
    run_op(32'hF0F0_AAAA, 32'hFF00_0F0F, 4'b1011, 1'b1, 1'b0, lat, bc);
    check_cnt++;
    if (f !== 32'hF000_0A0A) $display("FAIL and_f got %h want F0000A0A", f);
    else pass_cnt++;
    check_cnt++;
    if (lat !== 4) $display("FAIL and_latency got %0d want 4", lat);
    else pass_cnt++;
    check_cnt++;
    if (bc !== 4) $display("FAIL and_busy_cycles got %0d want 4", bc);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (done !== 1'b0) $display("FAIL and_done_width got %b want 0", done);
    else pass_cnt++;
  endtask

  task automatic test_ripple();
    int lat, bc;
    run_op(32'h0000_00FF, 32'h0000_0001, 4'b1001, 1'b0, 1'b0, lat, bc);
    check_cnt++;
    if (f !== 32'h0000_0100) $display("FAIL ripple_f got %h want 00000100", f);
    else pass_cnt++;
    check_cnt++;
    if (c_out !== 1'b0) $display("FAIL ripple_cout got %b want 0", c_out);
    else pass_cnt++;
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b1001, 1'b0, 1'b0, lat, bc);
    check_cnt++;
    if (f !== 32'h0000_0000) $display("FAIL wrap_f got %h want 00000000", f);
    else pass_cnt++;
    check_cnt++;
    if (c_out !== 1'b1) $display("FAIL wrap_cout got %b want 1", c_out);
    else pass_cnt++;
    run_op(32'h0000_00FF, 32'h0000_0000, 4'b1001, 1'b0, 1'b1, lat, bc);
    check_cnt++;
    if (f !== 32'h0000_0100) $display("FAIL cin_f got %h want 00000100", f);
    else pass_cnt++;
  endtask

  task automatic test_equality();
    int lat, bc;
    run_op(32'h1234_5678, 32'h1234_5678, 4'b0110, 1'b0, 1'b0, lat, bc);
    check_cnt++;
    if (a_eq_b !== 1'b1) $display("FAIL eq_same got %b want 1", a_eq_b);
    else pass_cnt++;
    check_cnt++;
    if (f !== 32'hFFFF_FFFF) $display("FAIL eq_same_f got %h want FFFFFFFF", f);
    else pass_cnt++;
    run_op(32'h1234_5678, 32'h1235_5678, 4'b0110, 1'b0, 1'b0, lat, bc);
    check_cnt++;
    if (a_eq_b !== 1'b0) $display("FAIL eq_diff got %b want 0", a_eq_b);
    else pass_cnt++;
    check_cnt++;
    if (f !== 32'hFFFE_FFFF) $display("FAIL eq_diff_f got %h want FFFEFFFF", f);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int dcount = 0;
    int bad_done = 0;
    @(negedge clk);
    a = 32'hFFFF_0000; b = 32'h0F0F_0F0F; s = 4'b1011; m = 1'b1; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (done) begin
        dcount++;
        if (k != 4 && k != 9 && k != 14) bad_done++;
      end
      if (k == 4) begin
        check_cnt++;
        if (f !== 32'h0F0F_0000) $display("FAIL b2b_op1 got %h want 0F0F0000", f);
        else pass_cnt++;
      end
      if (k == 7) begin
        check_cnt++;
        if (f !== 32'h0F0F_0000) $display("FAIL b2b_hold got %h want 0F0F0000", f);
        else pass_cnt++;
      end
      if (k == 9) begin
        check_cnt++;
        if (f !== 32'h1234_5678) $display("FAIL b2b_op2 got %h want 12345678", f);
        else pass_cnt++;
      end
      if (k == 14) begin
        check_cnt++;
        if (f !== 32'h00AA_5500) $display("FAIL b2b_op3 got %h want 00AA5500", f);
        else pass_cnt++;
      end
      if (k == 16) begin
        check_cnt++;
        if ({busy, done} !== 2'b00) $display("FAIL b2b_idle got %b want 00", {busy, done});
        else pass_cnt++;
      end
      case (k)
        0:  begin a = 32'h1234_5678; b = 32'hFFFF_FFFF; end
        5:  begin a = 32'hDEAD_BEEF; b = 32'hFFFF_FFFF; m = 1'b0; end
        9:  begin a = 32'hAAAA_5555; b = 32'h00FF_FF00; m = 1'b1; end
        10: begin a = 32'h0BAD_F00D; b = 32'hFFFF_FFFF; start = 1'b0; end
        default: ;
      endcase
    end
    start = 1'b0;
    check_cnt++;
    if (dcount !== 3 || bad_done !== 0) $display("FAIL b2b_done_pulses got %0d (misplaced %0d) want 3 (misplaced 0)", dcount, bad_done);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_exec();
    int lat, bc;
    int dcount = 0;
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'h1234_5678; s = 4'b1011; m = 1'b1; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_cnt++;
    if ({busy, done, c_out, a_eq_b} !== 4'b0000) $display("FAIL midrst_flags got %b want 0000", {busy, done, c_out, a_eq_b});
    else pass_cnt++;
    check_cnt++;
    if (f !== 32'h0) $display("FAIL midrst_f got %h want 00000000", f);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check_cnt++;
    if (dcount !== 0) $display("FAIL midrst_no_done got %0d want 0", dcount);
    else pass_cnt++;
    run_op(32'h0000_FFFF, 32'h0000_0001, 4'b1001, 1'b0, 1'b0, lat, bc);
    check_cnt++;
    if (f !== 32'h0001_0000) $display("FAIL midrst_after_f got %h want 00010000", f);
    else pass_cnt++;
    check_cnt++;
    if (lat !== 4 || a_eq_b !== 1'b0) $display("FAIL midrst_after_lat_eq got %0d/%b want 4/0", lat, a_eq_b);
    else pass_cnt++;
  endtask

  task automatic test_n_bytes_1();
    int lat = -1;
    int bc = 0;
    @(negedge clk);
    a1 = 8'hAA; b1 = 8'h55; s = 4'b0110; m = 1'b1; c_in = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy1) bc++;
      if (done1) begin
        lat = k;
        break;
      end
    end
    check_cnt++;
    if (f1 !== 8'hFF) $display("FAIL n1_f got %h want FF", f1);
    else pass_cnt++;
    check_cnt++;
    if (lat !== 1) $display("FAIL n1_latency got %0d want 1", lat);
    else pass_cnt++;
    check_cnt++;
    if (bc !== 1) $display("FAIL n1_busy_cycles got %0d want 1", bc);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_logic_and();
    test_ripple();
    test_equality();
    test_back_to_back();
    test_reset_mid_exec();
    test_n_bytes_1();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
